dma_write_controller: RTL and testbench
=======================================

// Module: dma_write_controller
// PURPOSE
//  AXI4 master write engine: result writeback path mirroring the read DMA. Accepts a
//  valid/ready stream of 32-bit result words from the compute core, buffers them in an
//  internal FIFO and writes them to memory as INCR bursts starting at base_addr.
//  Sits beside dma_controller under the accelerator top; the top FSM drives start/done.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  32  AXI address width
//  C_M_AXI_DATA_WIDTH  32  AXI data width (fixed 32; 4-byte beats)
//  MAX_BURST           16  max beats per burst (power of 2, 1..256)
//  FIFO_DEPTH          32  stream buffer depth in words (power of 2, >= MAX_BURST)
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   asynchronous active-low reset
//  start            in   1   1-cycle pulse: begin transfer (ignored while busy)
//  base_addr        in   32  byte address, aligned to MAX_BURST*4
//  transfer_length  in   32  number of 32-bit words to write
//  busy             out  1   transfer in progress
//  done             out  1   1-cycle pulse at completion
//  error            out  1   sticky: any BRESP != OKAY; cleared by next accepted start
//  s_data           in   32  result word
//  s_valid          in   1   s_data valid
//  s_ready          out  1   word accepted when s_valid && s_ready
//  m_axi_awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awvalid out, awready in
//  m_axi_wdata[32]/wstrb[4]/wlast/wvalid out, wready in
//  m_axi_bresp[2]/bvalid in, bready out
// BEHAVIOUR
//  Reset: busy,done,error,s_ready,awvalid,wvalid,wlast,bready=0; awaddr,awlen=0; FIFO empty.
//  Constants: awsize=3'b010, awburst=2'b01 (INCR), wstrb=4'hF.
//  Capture: start in IDLE latches base_addr/transfer_length; busy=1 next cycle.
//  transfer_length==0: no AXI traffic; done pulses, busy drops, cycle after start.
//  s_ready = busy && FIFO not full && words_accepted < transfer_length; excess not taken.
//  FSM: IDLE -> AW -> W -> B -> (AW | DONE) -> IDLE.
//   AW: beats = min(MAX_BURST, words_remaining); awvalid raised only once FIFO count
//       >= beats (W never starves); awlen=beats-1; hold stable until awready.
//   W : wvalid=1, wdata=FIFO head (first-word fall-through); pop on wvalid&&wready;
//       wlast=1 on beat beats-1 only; wdata/wvalid held stable while wready=0.
//   B : bready=1; on bvalid: error|=(bresp!=0); awaddr+=beats*4; remaining-=beats;
//       remaining==0 -> DONE else AW.
//   DONE: done=1 one cycle, busy=0 same cycle; return to IDLE.
//  One outstanding burst; AW issued before W. FIFO push and pop in same cycle keep count.
//  Aligned base + power-of-2 MAX_BURST guarantees no 4KB boundary crossing.
//  Error response does not abort; transfer completes, error stays set.
//  Reset mid-transfer: all state, counters, FIFO cleared; outputs to reset values at once.
//  Counters 32-bit; awaddr wraps modulo 2^C_M_AXI_ADDR_WIDTH (no wrap check).
// TESTING
//  len=16, base=0x1000, 16 words streamed, ready tied 1 -> one AW(0x1000,len 15),
//   16 beats wlast on 16th, done 1 cycle after B, error=0.
//  len=40, MAX_BURST=16 -> AW at 0x1000/0x1040/0x1080 awlen 15/15/7, data in order.
//  len=0 -> no awvalid ever; done pulses cycle after start.
//  Random wready/awready/bvalid stalls, s_valid gaps -> data/wlast stable under stall;
//   s_ready low when FIFO holds 32; exactly len words accepted.
//  bresp=2'b10 on 2nd of 3 bursts -> all 3 bursts complete, error=1 until next start.
//  rst_n low mid-W-burst -> outputs at reset values; fresh start len=4 completes cleanly.

Source files
------------

// File: rtl/dma_write_controller.sv
// AXI4 write DMA engine: buffers a 32-bit result stream in a FIFO and
// writes it to memory as INCR bursts of up to MAX_BURST beats.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start
// AW     | burst address pending; awvalid once FIFO holds the whole burst
// W      | streaming the burst data beats out of the FIFO
// B      | waiting for the write response of the current burst
// DONE   | one-cycle completion pulse, then back to IDLE
module dma_write_controller #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int MAX_BURST          = 16,
    parameter int FIFO_DEPTH         = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]                   transfer_length,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   addr_r;
    logic [31:0]     len_r;
    logic [31:0]     remaining;
    logic [31:0]     accepted;
    logic [8:0]      beats_r;
    logic [8:0]      beat_cnt;
    logic            error_r;

    logic [DW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    logic            busy_int;
    logic            fifo_full;
    logic            push, pop;
    logic            burst_ready;
    logic            last_beat;
    logic [31:0]     remaining_nxt;

    // Beats in the next burst: a full MAX_BURST or whatever is left.
    function automatic logic [8:0] burst_beats(input logic [31:0] words);
        if (words >= 32'(MAX_BURST))
            return 9'(MAX_BURST);
        else
            return words[8:0];
    endfunction

    assign busy_int      = (state == S_AW) || (state == S_W) || (state == S_B);
    assign fifo_full     = (count == CW'(FIFO_DEPTH));
    assign s_ready       = busy_int && !fifo_full && (accepted < len_r);
    assign push          = s_valid && s_ready;
    assign pop           = (state == S_W) && m_axi_wready;
    // Address is only offered once the whole burst is buffered, so W never starves.
    assign burst_ready   = 32'(count) >= 32'(beats_r);
    assign last_beat     = (beat_cnt == beats_r - 9'd1);
    assign remaining_nxt = remaining - 32'(beats_r);

    assign busy          = busy_int;
    assign error         = error_r;
    assign m_axi_awaddr  = addr_r;
    assign m_axi_awlen   = beats_r[7:0] - 8'd1;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wdata   = mem[rd_ptr];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt     = state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = (transfer_length == 32'd0) ? S_DONE : S_AW;
            end
            S_AW: begin
                m_axi_awvalid = burst_ready;
                if (burst_ready && m_axi_awready)
                    state_nxt = S_W;
            end
            S_W: begin
                m_axi_wvalid = 1'b1;
                m_axi_wlast  = last_beat;
                if (m_axi_wready && last_beat)
                    state_nxt = S_B;
            end
            S_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid)
                    state_nxt = (remaining_nxt == 32'd0) ? S_DONE : S_AW;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Transfer bookkeeping: capture on start, advance address/remaining per response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= '0;
            len_r     <= '0;
            remaining <= '0;
            beats_r   <= 9'd1;
            error_r   <= 1'b0;
        end else if (state == S_IDLE && start) begin
            addr_r    <= base_addr;
            len_r     <= transfer_length;
            remaining <= transfer_length;
            error_r   <= 1'b0;
            if (transfer_length != 32'd0)
                beats_r <= burst_beats(transfer_length);
        end else if (state == S_B && m_axi_bvalid) begin
            error_r   <= error_r | (m_axi_bresp != 2'b00);
            addr_r    <= addr_r + (AW'(beats_r) << 2);
            remaining <= remaining_nxt;
            if (remaining_nxt != 32'd0)
                beats_r <= burst_beats(remaining_nxt);
        end
    end

    // Beat position within the current burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            beat_cnt <= '0;
        else if (pop)
            beat_cnt <= last_beat ? 9'd0 : beat_cnt + 9'd1;
    end

    // Words taken from the stream in this transfer; caps intake at transfer_length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            accepted <= '0;
        else if (state == S_IDLE && start)
            accepted <= '0;
        else if (push)
            accepted <= accepted + 32'd1;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the pointers define emptiness.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_data;
    end

endmodule

// File: tb/tb_dma_write_controller.sv
// Testbench for dma_write_controller: random stream source and AXI slave,
// with expected bursts/data derived from transfer length and base address.
module tb_dma_write_controller;

    localparam int MAXB  = 16;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] transfer_length = '0;
    logic        busy, done, error;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    always #5 clk = ~clk;

    dma_write_controller #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .MAX_BURST(MAXB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .transfer_length(transfer_length),
        .busy(busy),
        .done(done),
        .error(error),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Environment state (source, slave, observation logs)
    logic [31:0] src_q[$];
    int          src_idx = 0;
    bit          s_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    bit          prev_w_stall = 0, prev_aw_stall = 0;
    logic [31:0] prev_wdata = '0;
    logic        prev_wlast = 1'b0;
    logic [31:0] prev_awaddr = '0;
    logic [7:0]  prev_awlen = '0;
    logic [31:0] aw_addr_log[$];
    logic [7:0]  aw_len_log[$];
    logic [31:0] w_data_log[$];
    bit          w_last_log[$];
    int          acc_cnt = 0, pop_cnt = 0, b_cnt = 0, b_pend = 0, b_dly = 0;
    int          done_cnt = 0, awv_seen = 0, err_burst = -1;
    int          gap_pct = 0, stall_pct = 0;
    int          cyc = 0, done_cyc = 0, b_cyc = 0;
    bit          saw_full = 0;

    // Source/slave driver (inputs change on negedge) and monitor (samples 1ns later)
    initial begin
        s_valid = 1'b0; s_data = '0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_valid = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
                s_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
                prev_w_stall = 0; prev_aw_stall = 0; b_pend = 0;
            end else begin
                if (s_hs) src_idx++;
                if (!(s_valid && !s_hs)) begin
                    if (src_idx < src_q.size() && int'($urandom_range(99)) >= gap_pct) begin
                        s_valid = 1'b1;
                        s_data  = src_q[src_idx];
                    end else begin
                        s_valid = 1'b0;
                    end
                end
                m_axi_awready = (int'($urandom_range(99)) >= stall_pct);
                m_axi_wready  = (int'($urandom_range(99)) >= stall_pct);
                if (b_hs) m_axi_bvalid = 1'b0;
                if (!m_axi_bvalid && b_pend > 0) begin
                    if (b_dly <= 0) begin
                        m_axi_bvalid = 1'b1;
                        m_axi_bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
                        b_pend--;
                        b_dly = (stall_pct > 0) ? int'($urandom_range(3)) : 0;
                    end else begin
                        b_dly--;
                    end
                end
                #1;
                cyc++;
                if (prev_w_stall) begin
                    n_cmp++;
                    if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== prev_wdata || m_axi_wlast !== prev_wlast) begin
                        n_fail++;
                        $display("FAIL w_stable: got wvalid=%0b wdata=%h wlast=%0b, want wvalid=1 wdata=%h wlast=%0b",
                                 m_axi_wvalid, m_axi_wdata, m_axi_wlast, prev_wdata, prev_wlast);
                    end
                end
                if (prev_aw_stall) begin
                    n_cmp++;
                    if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== prev_awaddr || m_axi_awlen !== prev_awlen) begin
                        n_fail++;
                        $display("FAIL aw_stable: got awvalid=%0b awaddr=%h awlen=%0d, want awvalid=1 awaddr=%h awlen=%0d",
                                 m_axi_awvalid, m_axi_awaddr, m_axi_awlen, prev_awaddr, prev_awlen);
                    end
                end
                if (acc_cnt - pop_cnt == DEPTH) begin
                    saw_full = 1;
                    n_cmp++;
                    if (s_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL fifo_full_ready: got s_ready=%0b with %0d words buffered, want 0", s_ready, DEPTH);
                    end
                end
                s_hs  = s_valid && (s_ready === 1'b1);
                aw_hs = (m_axi_awvalid === 1'b1) && m_axi_awready;
                w_hs  = (m_axi_wvalid === 1'b1) && m_axi_wready;
                b_hs  = m_axi_bvalid && (m_axi_bready === 1'b1);
                if (s_hs) acc_cnt++;
                if (aw_hs) begin
                    aw_addr_log.push_back(m_axi_awaddr);
                    aw_len_log.push_back(m_axi_awlen);
                end
                if (w_hs) begin
                    w_data_log.push_back(m_axi_wdata);
                    w_last_log.push_back(m_axi_wlast);
                    pop_cnt++;
                    if (m_axi_wlast) b_pend++;
                end
                if (b_hs) begin
                    b_cnt++;
                    b_cyc = cyc;
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (m_axi_awvalid === 1'b1) awv_seen++;
                prev_w_stall  = (m_axi_wvalid === 1'b1) && !m_axi_wready;
                prev_wdata    = m_axi_wdata;
                prev_wlast    = m_axi_wlast;
                prev_aw_stall = (m_axi_awvalid === 1'b1) && !m_axi_awready;
                prev_awaddr   = m_axi_awaddr;
                prev_awlen    = m_axi_awlen;
            end
        end
    end

    task automatic clear_agent();
        src_q.delete(); src_idx = 0;
        s_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        prev_w_stall = 0; prev_aw_stall = 0;
        aw_addr_log.delete(); aw_len_log.delete(); w_data_log.delete(); w_last_log.delete();
        acc_cnt = 0; pop_cnt = 0; b_cnt = 0; b_pend = 0; b_dly = 0;
        done_cnt = 0; awv_seen = 0; saw_full = 0; err_burst = -1;
        s_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if ({busy, done, error, s_ready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready} !== 8'h00) begin
            n_fail++;
            $display("FAIL %s_ctrl: got busy/done/error/s_ready/awvalid/wvalid/wlast/bready=%b, want 00000000", tag,
                     {busy, done, error, s_ready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready});
        end
        n_cmp++;
        if (m_axi_awaddr !== 32'h0 || m_axi_awlen !== 8'h0) begin
            n_fail++;
            $display("FAIL %s_aw: got awaddr=%h awlen=%0d, want 0/0", tag, m_axi_awaddr, m_axi_awlen);
        end
    endtask

    // Runs one transfer and compares everything observed with the reference model.
    task automatic run_transfer(input logic [31:0] base, input int len, input int extra,
                                input int gap, input int stall, input int errb, input bit glitch);
        int          start_cyc, k, limit, nb, nchk, beats, exp_done;
        logic [31:0] exp_addr;
        bit          exp_last, exp_err;
        clear_agent();
        gap_pct = gap; stall_pct = stall; err_burst = errb;
        for (int i = 0; i < len + extra; i++) src_q.push_back($urandom());
        @(negedge clk);
        start = 1'b1; base_addr = base; transfer_length = len;
        #2 start_cyc = cyc;
        @(negedge clk);
        start = 1'b0; base_addr = $urandom(); transfer_length = $urandom();
        #2;
        n_cmp++;
        if (busy !== (len != 0) || error !== 1'b0) begin
            n_fail++;
            $display("FAIL after_start: got busy=%0b error=%0b, want busy=%0b error=0", busy, error, len != 0);
        end
        k = 0;
        limit = len * 40 + 200;
        while (done_cnt == 0 && k < limit) begin
            @(negedge clk);
            if (glitch && k == 3) begin
                start = 1'b1; base_addr = 32'hDEAD_0000; transfer_length = 7;
            end else begin
                start = 1'b0;
            end
            #2 k++;
        end
        start = 1'b0;
        n_cmp++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL done_timeout: got no done within %0d cycles, want done (len=%0d)", limit, len);
        end
        repeat (6) begin @(negedge clk); #2; end

        n_cmp++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL done_count: got %0d done pulses, want 1", done_cnt);
        end
        exp_done = (len == 0) ? start_cyc + 1 : b_cyc + 1;
        n_cmp++;
        if (done_cyc != exp_done) begin
            n_fail++;
            $display("FAIL done_timing: got done at cycle %0d, want %0d", done_cyc, exp_done);
        end
        nb = (len + MAXB - 1) / MAXB;
        n_cmp++;
        if (aw_addr_log.size() != nb) begin
            n_fail++;
            $display("FAIL aw_count: got %0d bursts, want %0d", aw_addr_log.size(), nb);
        end
        nchk = (aw_addr_log.size() < nb) ? aw_addr_log.size() : nb;
        for (int i = 0; i < nchk; i++) begin
            beats    = (len - i * MAXB > MAXB) ? MAXB : len - i * MAXB;
            exp_addr = base + 32'(i * MAXB * 4);
            n_cmp++;
            if (aw_addr_log[i] !== exp_addr || aw_len_log[i] !== 8'(beats - 1)) begin
                n_fail++;
                $display("FAIL aw_burst%0d: got addr=%h len=%0d, want addr=%h len=%0d",
                         i, aw_addr_log[i], aw_len_log[i], exp_addr, beats - 1);
            end
        end
        n_cmp++;
        if (w_data_log.size() != len) begin
            n_fail++;
            $display("FAIL w_count: got %0d beats, want %0d", w_data_log.size(), len);
        end
        nchk = (w_data_log.size() < len) ? w_data_log.size() : len;
        for (int i = 0; i < nchk; i++) begin
            exp_last = ((i % MAXB) == MAXB - 1) || (i == len - 1);
            n_cmp++;
            if (w_data_log[i] !== src_q[i] || w_last_log[i] != exp_last) begin
                n_fail++;
                $display("FAIL w_beat%0d: got data=%h last=%0b, want data=%h last=%0b",
                         i, w_data_log[i], w_last_log[i], src_q[i], exp_last);
            end
        end
        n_cmp++;
        if (acc_cnt != len) begin
            n_fail++;
            $display("FAIL accepted: got %0d words taken, want %0d", acc_cnt, len);
        end
        exp_err = (errb >= 0) && (errb < nb);
        n_cmp++;
        if (error !== exp_err || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL end_state: got error=%0b busy=%0b, want error=%0b busy=0", error, busy, exp_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        n_cmp++;
        if (m_axi_awsize !== 3'b010 || m_axi_awburst !== 2'b01 || m_axi_wstrb !== 4'hF) begin
            n_fail++;
            $display("FAIL constants: got awsize=%b awburst=%b wstrb=%h, want 010/01/F",
                     m_axi_awsize, m_axi_awburst, m_axi_wstrb);
        end
        #2 rst_n = 1'b1;
        repeat (2) begin @(negedge clk); #2; end
    endtask

    task automatic test_single_burst();
        run_transfer(32'h0000_1000, 16, 0, 0, 0, -1, 0);
    endtask

    task automatic test_multi_burst();
        run_transfer(32'h0000_1000, 40, 0, 0, 0, -1, 0);
    endtask

    task automatic test_zero_len();
        run_transfer(32'h0000_5000, 0, 3, 0, 0, -1, 0);
        n_cmp++;
        if (awv_seen != 0) begin
            n_fail++;
            $display("FAIL zero_len_aw: got awvalid high for %0d cycles, want 0", awv_seen);
        end
    endtask

    task automatic test_random_stalls();
        int len;
        for (int it = 0; it < 4; it++) begin
            len = int'($urandom_range(100, 1));
            run_transfer($urandom() & 32'hFFFF_FFC0, len, 3, 30, 40, -1, len >= 16);
        end
        run_transfer(32'h0004_0000, 64, 5, 0, 70, -1, 1);
        n_cmp++;
        if (!saw_full) begin
            n_fail++;
            $display("FAIL fifo_fill: got max occupancy below %0d, want a full FIFO under heavy stall", DEPTH);
        end
    endtask

    task automatic test_error();
        run_transfer(32'h0000_1000, 40, 0, 10, 20, 1, 0);
        repeat (5) begin @(negedge clk); #2; end
        n_cmp++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL error_sticky: got error=%0b while idle, want 1", error);
        end
        run_transfer(32'h0000_2000, 4, 0, 0, 0, -1, 0);
    endtask

    task automatic test_reset_mid();
        int k;
        clear_agent();
        gap_pct = 0; stall_pct = 30;
        for (int i = 0; i < 32; i++) src_q.push_back($urandom());
        @(negedge clk);
        start = 1'b1; base_addr = 32'h0000_2000; transfer_length = 32;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(m_axi_wvalid === 1'b1 && pop_cnt >= 3) && k < 400) begin
            @(negedge clk); #2 k++;
        end
        n_cmp++;
        if (k >= 400) begin
            n_fail++;
            $display("FAIL mid_w_timeout: got no W activity within 400 cycles, want W burst in progress");
        end
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid");
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;
        clear_agent();
        run_transfer(32'h0000_3000, 4, 2, 0, 0, -1, 0);
    endtask

    task automatic test_back_to_back();
        run_transfer(32'hFFFF_FFC0, 32, 1, 0, 0, -1, 0);
        run_transfer(32'h0000_0040, 17, 2, 20, 20, -1, 0);
        run_transfer(32'h0001_0000, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_zero_len();
        test_random_stalls();
        test_error();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running at %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
